// File: rtl/uart_cmd_parser_pkg.sv
// Purpose: shared types and constants for the UART command-frame parser.
// Contents: FSM state encoding, err_code values, default frame header, checksum helper.
// Used by: uart_cmd_parser (top) and the testbench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam logic [7:0] DEFAULT_HEADER = 8'h55;

  // Frame checksum: 8-bit modular sum of address and data.
  function automatic logic [7:0] chk_sum(input logic [7:0] addr, input logic [7:0] data);
    return addr + data;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Purpose: byte-stream in / register-write + error status out bundle of the command parser.
// Ports: rx_done/rx_data (byte in), wr_en/wr_addr/wr_data (write strobe),
//        frame_err/err_code/err_cnt (rejects), busy (frame in progress).
interface uart_cmd_parser_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 rx_done;
  logic [7:0]           rx_data;
  logic                 wr_en;
  logic [7:0]           wr_addr;
  logic [7:0]           wr_data;
  logic                 frame_err;
  logic [1:0]           err_code;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_cnt;

  // UART receiver / stimulus side
  modport master (
    output rx_done, rx_data,
    input  wr_en, wr_addr, wr_data, frame_err, err_code, busy, err_cnt
  );

  // Parser side
  modport slave (
    input  rx_done, rx_data,
    output wr_en, wr_addr, wr_data, frame_err, err_code, busy, err_cnt
  );
endinterface

// File: rtl/uart_byte_timeout.sv
// Purpose: inter-byte watchdog; counts cycles while a frame is open.
// Latency: o_expire is combinational, high on the cycle the count reaches TIMEOUT_CYCLES.
// Ports: clk, rst (async, high), i_clr (restart count), i_en (count), o_expire (pulse).
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 104166
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires on the cycle whose increment would bring the count to TIMEOUT_CYCLES.
  // A byte arriving on that same cycle clears the count and wins.
  assign o_expire = i_en && !i_clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Purpose: assembles HEADER/ADDR/DATA[/CHK] byte frames into one-cycle register writes.
// Latency: wr_en and frame_err are registered, 1 cycle after the deciding byte or timeout.
// Backpressure: none; every rx_done byte is consumed. Stalled frames are dropped by timeout.
// Ports: clk, rst (async, active-high), bus (uart_cmd_parser_if.slave).
// Build option: define UART_CMD_CHKSUM_EN for 4-byte frames with checksum (err_code 01).
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER         = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYCLES = 104166,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.slave   bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_addr;
  logic                 r_wr_en;
  logic [7:0]           r_wr_addr;
  logic [7:0]           r_wr_data;
  logic                 r_frame_err;
  logic [1:0]           r_err_code;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_expire;
  logic                 w_lat_addr;
  logic                 w_wr_go;
  logic                 w_err_go;
  logic [1:0]           w_err_code;
  logic [7:0]           w_wr_data;

  uart_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (bus.rx_done || (r_state == IDLE)),
    .i_en     (r_state != IDLE),
    .o_expire (w_expire)
  );

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] r_data;
  logic       w_lat_data;
  assign w_wr_data = r_data;
`else
  // Without checksum the data byte is the final byte, so it goes straight to the write port.
  assign w_wr_data = bus.rx_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_lat_addr  = 1'b0;
    w_wr_go     = 1'b0;
    w_err_go    = 1'b0;
    w_err_code  = ERR_NONE;
`ifdef UART_CMD_CHKSUM_EN
    w_lat_data  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // Non-header bytes between frames are line noise and are dropped silently.
        if (bus.rx_done && (bus.rx_data == HEADER)) begin
          w_state_nxt = GET_ADDR;
        end
      end
      GET_ADDR: begin
        // A header value here is just an address; there is no resync.
        if (bus.rx_done) begin
          w_lat_addr  = 1'b1;
          w_state_nxt = GET_DATA;
        end else if (w_expire) begin
          w_err_go    = 1'b1;
          w_err_code  = ERR_TMO;
          w_state_nxt = IDLE;
        end
      end
      GET_DATA: begin
        if (bus.rx_done) begin
`ifdef UART_CMD_CHKSUM_EN
          w_lat_data  = 1'b1;
          w_state_nxt = GET_CHK;
`else
          w_wr_go     = 1'b1;
          w_state_nxt = IDLE;
`endif
        end else if (w_expire) begin
          w_err_go    = 1'b1;
          w_err_code  = ERR_TMO;
          w_state_nxt = IDLE;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      GET_CHK: begin
        if (bus.rx_done) begin
          if (bus.rx_data == chk_sum(r_addr, r_data)) begin
            w_wr_go    = 1'b1;
          end else begin
            w_err_go   = 1'b1;
            w_err_code = ERR_CHK;
          end
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_err_go    = 1'b1;
          w_err_code  = ERR_TMO;
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= '0;
`ifdef UART_CMD_CHKSUM_EN
      r_data      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_wr_en     <= w_wr_go;
      r_frame_err <= w_err_go;
      if (w_lat_addr) begin
        r_addr <= bus.rx_data;
      end
`ifdef UART_CMD_CHKSUM_EN
      if (w_lat_data) begin
        r_data <= bus.rx_data;
      end
`endif
      // Address/data hold after the strobe so the bank can sample late.
      if (w_wr_go) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_wr_data;
      end
      if (w_err_go) begin
        r_err_code <= w_err_code;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: self-checking bench for uart_cmd_parser against a frame-level reference model.
// Timing: inputs driven 1 time unit after posedge; outputs sampled on negedge.
// Build option: honours UART_CMD_CHKSUM_EN the same way as the design.
module tb_uart_cmd_parser;
  import uart_pkg::*;

  localparam int         T   = 50;
  localparam logic [7:0] HDR = 8'h55;
`ifdef UART_CMD_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int FLEN = CHK ? 4 : 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;
  int          checks = 0;
  int          errors = 0;

  // Observed and expected events: {cycle, addr, data} for writes, {cycle, 6'b0, code} for errors.
  logic [47:0] obs_wr[$];
  logic [47:0] exp_wr[$];
  logic [47:0] obs_err[$];
  logic [47:0] exp_err[$];

  // Reference model state: bytes of the open frame, cycle of its last byte, sticky outputs.
  logic [7:0]  frame[$];
  int          m_last;
  int          m_errcnt;
  logic [1:0]  m_code;
  logic [7:0]  m_wa;
  logic [7:0]  m_wd;

  uart_cmd_parser_if #(.ERR_CNT_W(8)) bus ();

  uart_cmd_parser #(
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (T),
    .ERR_CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1)     obs_wr.push_back({cyc, bus.wr_addr, bus.wr_data});
    if (bus.frame_err === 1'b1) obs_err.push_back({cyc, 6'b0, bus.err_code});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_err(input int c, input logic [1:0] code);
    exp_err.push_back({32'(c), 6'b0, code});
    m_code = code;
    if (m_errcnt < 255) m_errcnt++;
  endfunction

  // An open frame whose last byte is more than T cycles before 'upto' has timed out.
  function automatic void flush(input int upto);
    if (frame.size() != 0 && (m_last + T) < upto) begin
      push_err(m_last + T + 1, ERR_TMO);
      frame.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c);
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] s;
    flush(c);
    m_last = c;
    if (frame.size() != 0 || b == HDR) frame.push_back(b);
    if (frame.size() == FLEN) begin
      a = frame[1];
      d = frame[2];
      s = a + d;
      if (CHK && frame[FLEN-1] != s) begin
        push_err(c + 1, ERR_CHK);
      end else begin
        exp_wr.push_back({32'(c + 1), a, d});
        m_wa = a;
        m_wd = d;
      end
      frame.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle);
    repeat (idle) tick();
    model_byte(b, int'(cyc));
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                            input int gmin, input int gmax, input bit bad);
    logic [7:0] s;
    s = a + d;
    if (bad) s = s ^ 8'h5A;
    send_byte(HDR, $urandom_range(gmin, gmax));
    send_byte(a, $urandom_range(gmin, gmax));
    send_byte(d, $urandom_range(gmin, gmax));
    if (CHK) send_byte(s, $urandom_range(gmin, gmax));
  endtask

  task automatic check(input string tag);
    tick();
    tick();
    flush(int'(cyc) - 1);
    chk({tag, ".n_wr"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < obs_wr.size()) chk({tag, ".wr"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
    chk({tag, ".n_err"}, 64'(obs_err.size()), 64'(exp_err.size()));
    for (int i = 0; i < exp_err.size(); i++)
      if (i < obs_err.size()) chk({tag, ".err"}, 64'(obs_err[i]), 64'(exp_err[i]));
    obs_wr.delete();
    exp_wr.delete();
    obs_err.delete();
    exp_err.delete();
    chk({tag, ".busy"}, 64'(bus.busy), 64'(frame.size() != 0 && (m_last + T) >= int'(cyc)));
    chk({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(m_errcnt));
    chk({tag, ".err_code"}, 64'(bus.err_code), 64'(m_code));
    chk({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'(m_wa));
    chk({tag, ".wr_data"}, 64'(bus.wr_data), 64'(m_wd));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".wr_en"}, 64'(bus.wr_en), 64'd0);
    chk({tag, ".wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, ".wr_data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, ".frame_err"}, 64'(bus.frame_err), 64'd0);
    chk({tag, ".err_code"}, 64'(bus.err_code), 64'd0);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'd0);
  endtask

  function automatic void model_reset();
    frame.delete();
    m_last   = 0;
    m_errcnt = 0;
    m_code   = 2'b00;
    m_wa     = 8'h00;
    m_wd     = 8'h00;
  endfunction

  logic [7:0] nb;
  logic [7:0] ra;
  logic [7:0] rd;

  initial begin
    model_reset();
    rst         = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Basic frame 55,12,A7(,B9) with wide gaps.
    send_frame(8'h12, 8'hA7, 40, 40, 1'b0);
    check("basic");

    // Line noise before a frame is ignored.
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    send_byte(8'hAA, 3);
    send_frame(8'h01, 8'h02, 2, 2, 1'b0);
    check("noise");

`ifdef UART_CMD_CHKSUM_EN
    // Checksum mismatch then the corrected frame.
    send_byte(HDR, 2);
    send_byte(8'h10, 2);
    send_byte(8'h20, 2);
    send_byte(8'h31, 2);
    check("chk_bad");
    send_byte(HDR, 2);
    send_byte(8'h10, 2);
    send_byte(8'h20, 2);
    send_byte(8'h30, 2);
    check("chk_good");
`endif

    // Stall after the address: timeout, busy drops, next frame still works.
    send_byte(HDR, 2);
    send_byte(8'h33, 2);
    check("stall_mid");
    repeat (T + 5) tick();
    check("timeout");
    send_frame(8'($urandom), 8'($urandom), 1, 5, 1'b0);
    check("after_tmo");

    // Data byte on the exact expiry cycle is accepted.
    send_byte(HDR, 3);
    send_byte(8'h21, 3);
    send_byte(8'h9C, T - 1);
    if (CHK) send_byte(8'hBD, 3);
    check("expiry_edge");
    // One cycle later the frame has already timed out.
    send_byte(HDR, 3);
    send_byte(8'h21, 3);
    send_byte(8'h9C, T);
    if (CHK) send_byte(8'hBD, 3);
    repeat (T + 5) tick();
    check("expiry_late");

    // Back-to-back frames: header lands on the cycle wr_en is high.
    send_frame(8'h40, 8'h41, 0, 0, 1'b0);
    send_frame(8'h50, 8'h51, 0, 0, 1'b0);
    send_frame(8'h60, 8'h61, 0, 0, 1'b0);
    check("b2b");

    // Randomized frames, noise, bad checksums and occasional timeouts.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        if (nb == HDR) nb = 8'h00;
        send_byte(nb, $urandom_range(0, 8));
      end
      ra = 8'($urandom);
      rd = 8'($urandom);
      send_frame(ra, rd, 0, T + 6, $urandom_range(0, 3) == 0);
      check("soak");
    end
    repeat (T + 5) tick();
    check("soak_drain");

    // Forced timeouts until the error counter saturates.
    for (int k = 0; k < 300; k++) send_byte(HDR, T + 1);
    repeat (T + 5) tick();
    check("saturate");
    chk("err_cnt_ff", 64'(bus.err_cnt), 64'hFF);

    // Reset in the middle of a frame.
    send_byte(HDR, 2);
    send_byte(8'h44, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    model_reset();
    tick();
    rst = 1'b0;
    send_byte(8'h66, 3);
    send_byte(8'h01, 3);
    if (CHK) send_byte(8'h67, 3);
    check("post_reset");

    send_frame(8'hC3, 8'h3C, 1, 4, 1'b0);
    check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
